// File: rtl/exp4_unidade_controle_pkg.sv
// Shared types for the exp4 control unit: state encoding and the control/status output bundle.
package exp4_unidade_controle_pkg;
`include "exp4_estados.vh"

   typedef enum logic [3:0] {
      StInicial   = `EXP4_INICIAL,
      StPrepara   = `EXP4_PREPARA,
      StEspera    = `EXP4_ESPERA,
      StRegistra  = `EXP4_REGISTRA,
      StCompara   = `EXP4_COMPARA,
      StProximo   = `EXP4_PROXIMO,
      StFimAcerto = `EXP4_FIM_ACERTO,
      StFimTmo    = `EXP4_FIM_TMO,
      StFimErro   = `EXP4_FIM_ERRO
   } estado_e;

   typedef struct packed {
      logic zera_c;
      logic conta_c;
      logic zera_r;
      logic registrar_r;
      logic pronto;
      logic acertou;
      logic errou;
      logic timeout;
   } ctrl_t;

endpackage

// File: rtl/contador_timeout.sv
// ESPERA watchdog counter: synchronous clear, enable, fim_o flags count == M-1.
module contador_timeout #(
   parameter int unsigned M = 3000,
   parameter int unsigned W = 12
) (
   input  logic clk_i,
   input  logic clr_i,
   input  logic en_i,
   output logic fim_o
);

   logic [W-1:0] cnt_q, cnt_d;

   assign fim_o = (cnt_q == W'(M - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !fim_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

endmodule

// File: rtl/exp4_estados.vh
// 4-bit state codes of the exp4 control unit, shared by the FSM and the debug display.
`ifndef EXP4_ESTADOS_VH
`define EXP4_ESTADOS_VH
`define EXP4_INICIAL    4'h0
`define EXP4_PREPARA    4'h1
`define EXP4_ESPERA     4'h2
`define EXP4_REGISTRA   4'h4
`define EXP4_COMPARA    4'h5
`define EXP4_PROXIMO    4'h6
`define EXP4_FIM_ACERTO 4'hA
`define EXP4_FIM_TMO    4'hD
`define EXP4_FIM_ERRO   4'hE
`endif

// File: rtl/exp4_unidade_controle.sv
// Moore FSM sequencing the exp4 datapath through 16 plays; optional ESPERA timeout
// is compiled in with EXP4_TIMEOUT_EN.
module exp4_unidade_controle
   import exp4_unidade_controle_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 3000,
   parameter int unsigned TMO_W          = 12
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada_feita,
   input  logic       igual,
   input  logic       fimC,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registrarR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] db_estado
);

   if ((64'd1 << TMO_W) < 64'(TIMEOUT_CYCLES)) begin : g_tmo_w_chk
      $error("TMO_W too narrow for TIMEOUT_CYCLES");
   end

   estado_e estado_q, estado_d;
   ctrl_t   ctrl;

`ifdef EXP4_TIMEOUT_EN
   logic tmo_fim;

   // Counter only advances in ESPERA, so every ESPERA entry restarts the window.
   contador_timeout #(
      .M (TIMEOUT_CYCLES),
      .W (TMO_W)
   ) u_contador_timeout (
      .clk_i (clock),
      .clr_i (!reset || (estado_q != StEspera)),
      .en_i  (estado_q == StEspera),
      .fim_o (tmo_fim)
   );
`endif

   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q <= StInicial;
      end else begin
         estado_q <= estado_d;
      end
   end

   always_comb begin
      estado_d = estado_q;
      ctrl     = '0;
      case (estado_q)
         StInicial: begin
            if (iniciar) estado_d = StPrepara;
         end
         StPrepara: begin
            ctrl.zera_c = 1'b1;
            ctrl.zera_r = 1'b1;
            estado_d    = StEspera;
         end
         StEspera: begin
            if (jogada_feita) begin
               estado_d = StRegistra;
`ifdef EXP4_TIMEOUT_EN
            end else if (tmo_fim) begin
               estado_d = StFimTmo;
`endif
            end
         end
         StRegistra: begin
            ctrl.registrar_r = 1'b1;
            estado_d         = StCompara;
         end
         StCompara: begin
            if (!igual)    estado_d = StFimErro;
            else if (fimC) estado_d = StFimAcerto;
            else           estado_d = StProximo;
         end
         StProximo: begin
            ctrl.conta_c = 1'b1;
            estado_d     = StEspera;
         end
         StFimAcerto: begin
            ctrl.pronto  = 1'b1;
            ctrl.acertou = 1'b1;
            if (iniciar) estado_d = StPrepara;
         end
         StFimErro: begin
            ctrl.pronto = 1'b1;
            ctrl.errou  = 1'b1;
            if (iniciar) estado_d = StPrepara;
         end
`ifdef EXP4_TIMEOUT_EN
         StFimTmo: begin
            ctrl.pronto  = 1'b1;
            ctrl.timeout = 1'b1;
            if (iniciar) estado_d = StPrepara;
         end
`endif
         default: estado_d = StInicial;
      endcase
   end

   assign zeraC      = ctrl.zera_c;
   assign contaC     = ctrl.conta_c;
   assign zeraR      = ctrl.zera_r;
   assign registrarR = ctrl.registrar_r;
   assign pronto     = ctrl.pronto;
   assign acertou    = ctrl.acertou;
   assign errou      = ctrl.errou;
   assign timeout    = ctrl.timeout;
   assign db_estado  = estado_q;

endmodule

// File: tb/tb_exp4_unidade_controle.sv
// Bench for exp4_unidade_controle: randomized rounds checked cycle by cycle against a
// play-timeline model; timeout scenarios run only when built with EXP4_TIMEOUT_EN.
module tb_exp4_unidade_controle;

`ifdef EXP4_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif
   localparam int TMO_N = 8;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       iniciar = 1'b0;
   logic       jogada_feita = 1'b0;
   logic       igual = 1'b0;
   logic       fimC = 1'b0;
   logic       zeraC, contaC, zeraR, registrarR, pronto, acertou, errou, timeout;
   logic [3:0] db_estado;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [3:0] cur_code = 4'h0;

   always #5 clock = ~clock;

   exp4_unidade_controle #(
      .TIMEOUT_CYCLES (TMO_N),
      .TMO_W          (4)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .iniciar      (iniciar),
      .jogada_feita (jogada_feita),
      .igual        (igual),
      .fimC         (fimC),
      .zeraC        (zeraC),
      .contaC       (contaC),
      .zeraR        (zeraR),
      .registrarR   (registrarR),
      .pronto       (pronto),
      .acertou      (acertou),
      .errou        (errou),
      .timeout      (timeout),
      .db_estado    (db_estado)
   );

   // {db_estado, zeraC, contaC, zeraR, registrarR, pronto, acertou, errou, timeout}
   function automatic logic [11:0] obs();
      return {db_estado, zeraC, contaC, zeraR, registrarR, pronto, acertou, errou, timeout};
   endfunction

   function automatic logic [11:0] exp_vec(input logic [3:0] code);
      logic [7:0] o;
      case (code)
         4'h1:    o = 8'b1010_0000;
         4'h4:    o = 8'b0001_0000;
         4'h6:    o = 8'b0100_0000;
         4'hA:    o = 8'b0000_1100;
         4'hE:    o = 8'b0000_1010;
         4'hD:    o = 8'b0000_1001;
         default: o = 8'b0000_0000;
      endcase
      return {code, o};
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // One round from INICIAL or an end state. dly[i] = idle ESPERA cycles before play i.
   task automatic run_round(input string tag, input int err_at, input int dly[16],
                            input bit inject, output int edges);
      logic [3:0] e;
      int         nreg, ncont, exp_reg, exp_cont;
      bit         done;
      nreg = 0; ncont = 0; exp_reg = 0; exp_cont = 0; done = 0; edges = 0;
      iniciar = 1'b1; jogada_feita = 1'b0;
      tick();
      n_cmp++;
      if (obs() !== exp_vec(4'h1)) begin
         n_err++; $display("FAIL %s start: got %h want %h", tag, obs(), exp_vec(4'h1));
      end
      iniciar = inject ? 1'($urandom_range(0, 1)) : 1'b0;
      e = 4'h2;
      tick(); edges++;
      n_cmp++;
      if (obs() !== exp_vec(e)) begin
         n_err++; $display("FAIL %s prepara: got %h want %h", tag, obs(), exp_vec(e));
      end
      for (int i = 0; i < 16 && !done; i++) begin
         igual = (i != err_at);
         fimC  = (i == 15);
         for (int k = 0; k <= dly[i]; k++) begin
            jogada_feita = (k == dly[i]);
            if (inject) iniciar = 1'($urandom_range(0, 1));
            tick(); edges++;
            if (k == dly[i]) e = 4'h4;
            else if (TMO_ON && k == TMO_N - 1) e = 4'hD;
            else e = 4'h2;
            n_cmp++;
            if (obs() !== exp_vec(e)) begin
               n_err++;
               $display("FAIL %s espera p%0d k%0d: got %h want %h", tag, i, k, obs(), exp_vec(e));
            end
            if (registrarR) nreg++;
            if (e != 4'h2) break;
         end
         if (e == 4'hD) begin
            done = 1;
         end else begin
            exp_reg++;
            for (int s = 0; s < 3 && !done; s++) begin
               // Pulses here land outside ESPERA and must be lost.
               jogada_feita = inject ? 1'($urandom_range(0, 1)) : 1'b0;
               if (inject) iniciar = 1'($urandom_range(0, 1));
               tick(); edges++;
               if (s == 0) e = 4'h5;
               else if (s == 1) e = (i == err_at) ? 4'hE : (i == 15) ? 4'hA : 4'h6;
               else e = 4'h2;
               n_cmp++;
               if (obs() !== exp_vec(e)) begin
                  n_err++;
                  $display("FAIL %s play%0d step%0d: got %h want %h", tag, i, s, obs(), exp_vec(e));
               end
               if (registrarR) nreg++;
               if (contaC) ncont++;
               if (e == 4'h6) exp_cont++;
               if (e == 4'hA || e == 4'hE) done = 1;
            end
         end
      end
      n_cmp++;
      if (nreg !== exp_reg) begin
         n_err++; $display("FAIL %s registrarR count: got %0d want %0d", tag, nreg, exp_reg);
      end
      n_cmp++;
      if (ncont !== exp_cont) begin
         n_err++; $display("FAIL %s contaC count: got %0d want %0d", tag, ncont, exp_cont);
      end
      cur_code = e;
      iniciar = 1'b0;
      for (int h = 0; h < 3; h++) begin
         jogada_feita = 1'($urandom_range(0, 1));
         tick();
         n_cmp++;
         if (obs() !== exp_vec(cur_code)) begin
            n_err++; $display("FAIL %s hold%0d: got %h want %h", tag, h, obs(), exp_vec(cur_code));
         end
      end
      jogada_feita = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; iniciar = 1'b1; jogada_feita = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick(); n_cmp++;
         if (obs() !== exp_vec(4'h0)) begin
            n_err++; $display("FAIL reset_init%0d: got %h want %h", c, obs(), exp_vec(4'h0));
         end
      end
      reset = 1'b1; iniciar = 1'b1; jogada_feita = 1'b0;
      tick();
      iniciar = 1'b0;
      tick(); n_cmp++;
      if (obs() !== exp_vec(4'h2)) begin
         n_err++; $display("FAIL reset_reach_espera: got %h want %h", obs(), exp_vec(4'h2));
      end
      // Reset must win over a simultaneous play and start request.
      reset = 1'b0; iniciar = 1'b1; jogada_feita = 1'b1;
      for (int c = 0; c < 2; c++) begin
         tick(); n_cmp++;
         if (obs() !== exp_vec(4'h0)) begin
            n_err++; $display("FAIL reset_mid%0d: got %h want %h", c, obs(), exp_vec(4'h0));
         end
      end
      reset = 1'b1; iniciar = 1'b0; jogada_feita = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick(); n_cmp++;
         if (obs() !== exp_vec(4'h0)) begin
            n_err++; $display("FAIL reset_idle%0d: got %h want %h", c, obs(), exp_vec(4'h0));
         end
      end
      cur_code = 4'h0;
   endtask

   task automatic test_full_round();
      int d[16];
      int edges;
      foreach (d[i]) d[i] = 0;
      run_round("full", -1, d, 1'b0, edges);
      n_cmp++;
      if (edges !== 64) begin
         n_err++; $display("FAIL full_latency: got %0d want %0d", edges, 64);
      end
   endtask

   task automatic test_error();
      int d[16];
      int edges;
      foreach (d[i]) d[i] = $urandom_range(0, 3);
      run_round("erro3", 2, d, 1'b0, edges);
      // Restart from FIM_ERRO: exactly one PREPARA cycle.
      foreach (d[i]) d[i] = 0;
      run_round("restart", 0, d, 1'b0, edges);
   endtask

   task automatic test_ignored();
      int d[16];
      int edges;
      foreach (d[i]) d[i] = $urandom_range(0, 2);
      run_round("inject_ok", -1, d, 1'b1, edges);
      foreach (d[i]) d[i] = $urandom_range(0, 2);
      run_round("inject_err", int'($urandom_range(4, 12)), d, 1'b1, edges);
   endtask

   task automatic test_back_to_back();
      int d[16];
      int edges;
      int err_at;
      for (int r = 0; r < 6; r++) begin
         foreach (d[i]) d[i] = ($urandom_range(0, 15) == 0) ? $urandom_range(0, 6)
                                                            : $urandom_range(0, 3);
         err_at = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 15));
         run_round($sformatf("b2b%0d", r), err_at, d, r[0], edges);
      end
   endtask

`ifdef EXP4_TIMEOUT_EN
   task automatic test_timeout();
      int d[16];
      int edges;
      foreach (d[i]) d[i] = 0;
      d[0] = 20;
      run_round("tmo_first", -1, d, 1'b0, edges);
      foreach (d[i]) d[i] = 1;
      d[5] = 12;
      run_round("tmo_mid", -1, d, 1'b1, edges);
      foreach (d[i]) d[i] = TMO_N - 1;
      run_round("tmo_expiry_play", -1, d, 1'b0, edges);
   endtask
`else
   task automatic test_no_timeout();
      iniciar = 1'b1; jogada_feita = 1'b0;
      tick();
      iniciar = 1'b0;
      tick();
      for (int c = 0; c < 10000; c++) begin
         iniciar = 1'($urandom_range(0, 1));
         tick(); n_cmp++;
         if (obs() !== exp_vec(4'h2)) begin
            n_err++; $display("FAIL idle_espera%0d: got %h want %h", c, obs(), exp_vec(4'h2));
         end
      end
      iniciar = 1'b0;
      reset = 1'b0;
      tick();
      reset = 1'b1;
      cur_code = 4'h0;
   endtask
`endif

   initial begin
      test_reset();
      test_full_round();
      test_error();
      test_ignored();
      test_back_to_back();
`ifdef EXP4_TIMEOUT_EN
      test_timeout();
`else
      test_no_timeout();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
